// File: rtl/seg7_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_decoder_pkg
//  Description : Shared constants for the scanned 7-segment decoder: the
//                active-low segment patterns of the ten digits and blank,
//                the special output codes, FSM state encoding and the
//                default settle count.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_scan_decoder_pkg;

    // Settle count used when the parent does not override it
    localparam int c_SETTLE_DEFAULT = 4;

    // Segment patterns, active-low, bit 6 = g ... bit 0 = a
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    // Output codes for a dark digit and for an unrecognised pattern
    localparam logic [3:0] c_CODE_BLANK   = 4'hF;
    localparam logic [3:0] c_CODE_ILLEGAL = 4'hE;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_TRACK = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_TRACK = c_ST_TRACK,
        ST_HOLD  = c_ST_HOLD
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pattern_decode
//  Description : Combinational lookup from an active-low 7-segment pattern
//                to a 4-bit code: 0..9 for digits, F for blank, E otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
    import seg7_scan_decoder_pkg::*;
(
    input  logic [6:0] iSeg,
    output logic [3:0] oCode
);

    // Exact-match table; anything not listed is reported as illegal
    always_comb begin
        oCode = c_CODE_ILLEGAL;
        case (iSeg)
            c_SEG_0:     oCode = 4'd0;
            c_SEG_1:     oCode = 4'd1;
            c_SEG_2:     oCode = 4'd2;
            c_SEG_3:     oCode = 4'd3;
            c_SEG_4:     oCode = 4'd4;
            c_SEG_5:     oCode = 4'd5;
            c_SEG_6:     oCode = 4'd6;
            c_SEG_7:     oCode = 4'd7;
            c_SEG_8:     oCode = 4'd8;
            c_SEG_9:     oCode = 4'd9;
            c_SEG_BLANK: oCode = c_CODE_BLANK;
            default:     oCode = c_CODE_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_decoder
//  Description : Recovers the four digits shown on a multiplexed, active-low
//                7-segment display by sampling its segment and anode lines.
//                A digit is accepted after SETTLE identical samples; once all
//                four digits have been seen a complete frame is published.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_scan_decoder_pkg::*;
#(
    parameter int SETTLE = c_SETTLE_DEFAULT   // legal range 2..255
)
(
    input  logic        iClk,
    input  logic        iRst,
    input  logic [6:0]  iSeg,
    input  logic [3:0]  iAn,
    output logic [15:0] oBcd,
    output logic [3:0]  oValid,
    output logic        oFrame,
    output logic        oErr
);

    localparam logic [7:0] c_SETTLE_CNT = 8'(SETTLE);

    state_t      r_state;
    logic [3:0]  r_trackAn;
    logic [6:0]  r_trackSeg;
    logic [7:0]  r_count;
    logic [3:0]  r_seen;
    logic [15:0] r_stageBcd;
    logic [3:0]  r_stageValid;

    logic [3:0]  w_code;
    logic [1:0]  w_digitIdx;
    logic        w_single;
    logic        w_none;
    logic        w_multi;
    logic        w_hit;

    seg7_pattern_decode u_decode (
        .iSeg  (iSeg),
        .oCode (w_code)
    );

    // Classify the anode sample and find which digit a single enable selects
    always_comb begin
        w_single   = 1'b1;
        w_digitIdx = 2'd0;
        case (iAn)
            4'b1110: w_digitIdx = 2'd0;
            4'b1101: w_digitIdx = 2'd1;
            4'b1011: w_digitIdx = 2'd2;
            4'b0111: w_digitIdx = 2'd3;
            default: w_single   = 1'b0;
        endcase
        w_none  = (iAn == 4'b1111);
        w_multi = !w_single && !w_none;
        // Sample repeats the one being tracked or held
        w_hit   = w_single && (iAn == r_trackAn) && (iSeg == r_trackSeg);
    end

    // Settle tracking, digit capture, frame publication and error flag
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state      <= ST_IDLE;
            r_trackAn    <= 4'hF;
            r_trackSeg   <= c_SEG_BLANK;
            r_count      <= 8'd0;
            r_seen       <= 4'b0000;
            r_stageBcd   <= 16'hFFFF;
            r_stageValid <= 4'b0000;
            oBcd         <= 16'hFFFF;
            oValid       <= 4'b0000;
            oFrame       <= 1'b0;
            oErr         <= 1'b0;
        end else begin
            oFrame <= 1'b0;

            // A capture never lands in the cycle right after another one,
            // so publishing here cannot race with a new seen bit.
            if (r_seen == 4'hF) begin
                oFrame <= 1'b1;
                oBcd   <= r_stageBcd;
                oValid <= r_stageValid;
                r_seen <= 4'b0000;
            end

            if (w_multi) begin
                oErr    <= 1'b1;
                r_count <= 8'd0;
                r_state <= ST_IDLE;
            end else if (r_state == ST_TRACK && w_hit) begin
                if (r_count + 8'd1 == c_SETTLE_CNT) begin
                    r_count                          <= c_SETTLE_CNT;
                    r_state                          <= ST_HOLD;
                    r_stageBcd[{w_digitIdx, 2'b00} +: 4] <= w_code;
                    r_stageValid[w_digitIdx]         <= (w_code != c_CODE_ILLEGAL);
                    r_seen[w_digitIdx]               <= 1'b1;
                    if (w_code == c_CODE_ILLEGAL) begin
                        oErr <= 1'b1;
                    end
                end else begin
                    r_count <= r_count + 8'd1;
                end
            end else if (r_state == ST_HOLD && w_hit) begin
                // Digit already captured; counter stays saturated
                r_state <= ST_HOLD;
            end else if (w_single) begin
                // New or changed digit: start tracking it from this sample
                r_trackAn  <= iAn;
                r_trackSeg <= iSeg;
                r_count    <= 8'd1;
                r_state    <= ST_TRACK;
            end else begin
                r_count <= 8'd0;
                r_state <= ST_IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_decoder
//  Description : Self-checking bench for seg7_scan_decoder. A run-length
//                reference model predicts every output each cycle; directed
//                scenarios are followed by randomized scanning.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int SETTLE = 4;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [6:0]  iSeg = 7'h7F;
    logic [3:0]  iAn  = 4'hF;
    logic [15:0] oBcd;
    logic [3:0]  oValid;
    logic        oFrame;
    logic        oErr;

    seg7_scan_decoder #(.SETTLE(SETTLE)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iSeg   (iSeg),
        .iAn    (iAn),
        .oBcd   (oBcd),
        .oValid (oValid),
        .oFrame (oFrame),
        .oErr   (oErr)
    );

    always #5 iClk = ~iClk;

    // Reference segment table, index = digit value
    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000};

    int nChecks = 0;
    int nPass   = 0;
    int nFrames = 0;

    // Reference model state: length of the current run of identical samples
    int          mRun;
    logic [3:0]  mAn;
    logic [6:0]  mSeg;
    logic [3:0]  mSeen;
    logic [15:0] mStage;
    logic [3:0]  mStageValid;
    logic [15:0] eBcd;
    logic [3:0]  eValid;
    logic        eFrame;
    logic        eErr;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [3:0] refDecode(input logic [6:0] seg);
        for (int d = 0; d < 10; d++) if (seg == pat[d]) return 4'(d);
        if (seg == 7'h7F) return 4'hF;
        return 4'hE;
    endfunction

    function automatic logic [3:0] anOf(input int d);
        logic [3:0] one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic modelReset();
        mRun = 0; mAn = 4'hF; mSeg = 7'h7F; mSeen = 4'h0;
        mStage = 16'hFFFF; mStageValid = 4'h0;
        eBcd = 16'hFFFF; eValid = 4'h0; eFrame = 1'b0; eErr = 1'b0;
    endtask

    // One clock edge of the specified behaviour
    task automatic modelEdge(input logic [3:0] an, input logic [6:0] seg);
        int zeros;
        int d;
        logic [3:0] code;
        eFrame = 1'b0;
        if (mSeen == 4'hF) begin
            eFrame = 1'b1; eBcd = mStage; eValid = mStageValid; mSeen = 4'h0;
        end
        zeros = $countones(~an);
        if (zeros > 1) begin
            eErr = 1'b1; mRun = 0;
        end else if (zeros == 0) begin
            mRun = 0;
        end else begin
            if (mRun > 0 && an == mAn && seg == mSeg) mRun++;
            else begin mRun = 1; mAn = an; mSeg = seg; end
            if (mRun == SETTLE) begin
                d = 0;
                for (int k = 0; k < 4; k++) if (!an[k]) d = k;
                code = refDecode(seg);
                mStage[d*4 +: 4] = code;
                mStageValid[d]   = (code != 4'hE);
                mSeen[d]         = 1'b1;
                if (code == 4'hE) eErr = 1'b1;
            end
        end
    endtask

    task automatic compareOuts();
        checkVal("bcd",   32'(oBcd),   32'(eBcd));
        checkVal("valid", 32'(oValid), 32'(eValid));
        checkVal("frame", 32'(oFrame), 32'(eFrame));
        checkVal("err",   32'(oErr),   32'(eErr));
    endtask

    task automatic step(input logic [3:0] an, input logic [6:0] seg);
        iAn = an; iSeg = seg;
        @(posedge iClk);
        modelEdge(an, seg);
        #1;
        if (oFrame) nFrames++;
        compareOuts();
    endtask

    task automatic hold(input int d, input logic [6:0] seg, input int n);
        for (int i = 0; i < n; i++) step(anOf(d), seg);
    endtask

    task automatic doReset();
        @(negedge iClk);
        iRst = 1'b1; iAn = 4'hF; iSeg = 7'h7F;
        #1;
        modelReset();
        nFrames = 0;
        compareOuts();
        @(negedge iClk);
        iRst = 1'b0;
    endtask

    initial begin
        logic [3:0] an;
        logic [6:0] seg;
        int r;
        modelReset();

        // Basic frame 4321
        doReset();
        hold(0, pat[1], 4); hold(1, pat[2], 4); hold(2, pat[3], 4); hold(3, pat[4], 4);
        step(4'hF, 7'h7F);
        checkVal("s1_frames", nFrames, 1);
        checkVal("s1_bcd", 32'(oBcd), 32'h4321);
        checkVal("s1_valid", 32'(oValid), 32'hF);
        checkVal("s1_err", 32'(oErr), 0);

        // Digit 0 held too briefly, then properly
        doReset();
        hold(0, pat[1], 3); hold(1, pat[2], 4); hold(2, pat[3], 4); hold(3, pat[4], 4);
        step(4'hF, 7'h7F); step(4'hF, 7'h7F);
        checkVal("s2_noframe", nFrames, 0);
        checkVal("s2_bcd_hold", 32'(oBcd), 32'hFFFF);
        hold(0, pat[1], 4);
        step(4'hF, 7'h7F);
        checkVal("s2_frames", nFrames, 1);
        checkVal("s2_bcd", 32'(oBcd), 32'h4321);

        // Illegal pattern on digit 2
        doReset();
        hold(0, pat[1], 4); hold(1, pat[2], 4); hold(2, 7'b1010101, 4); hold(3, pat[4], 4);
        step(4'hF, 7'h7F);
        checkVal("s3_bcd", 32'(oBcd), 32'h4E21);
        checkVal("s3_valid", 32'(oValid), 32'b1011);
        for (int i = 0; i < 5; i++) step(4'hF, 7'h7F);
        checkVal("s3_err_sticky", 32'(oErr), 1);

        // Multi-anode sample during tracking discards the partial count
        doReset();
        hold(0, pat[1], 2);
        step(4'b1100, pat[1]);
        checkVal("s4_err", 32'(oErr), 1);
        hold(0, pat[1], 3); hold(1, pat[2], 4); hold(2, pat[3], 4); hold(3, pat[4], 4);
        step(4'hF, 7'h7F); step(4'hF, 7'h7F);
        checkVal("s4_noframe", nFrames, 0);

        // All digits blank
        doReset();
        for (int d = 0; d < 4; d++) hold(d, 7'h7F, 4);
        step(4'hF, 7'h7F);
        checkVal("s5_frames", nFrames, 1);
        checkVal("s5_bcd", 32'(oBcd), 32'hFFFF);
        checkVal("s5_valid", 32'(oValid), 32'hF);

        // Reset mid-frame discards the partial frame
        doReset();
        hold(0, pat[5], 4); hold(1, pat[6], 4); hold(2, pat[7], 4);
        doReset();
        hold(3, pat[8], 4);
        for (int i = 0; i < 3; i++) step(4'hF, 7'h7F);
        checkVal("s6_noframe", nFrames, 0);
        checkVal("s6_bcd", 32'(oBcd), 32'hFFFF);
        checkVal("s6_valid", 32'(oValid), 0);

        // Randomized scanning against the model
        doReset();
        for (int t = 0; t < 1500; t++) begin
            r   = $urandom_range(0, 19);
            an  = anOf($urandom_range(0, 3));
            seg = pat[$urandom_range(0, 9)];
            if (r == 16) seg = 7'h7F;
            else if (r == 17) seg = 7'($urandom);
            if (r == 18) begin
                step(4'hF, 7'($urandom));
            end else if (r == 19 && $urandom_range(0, 3) == 0) begin
                an = 4'($urandom) & ~anOf($urandom_range(0, 3));
                an[$urandom_range(0, 3)] = 1'b0;
                if ($countones(~an) < 2) an = 4'b0000;
                step(an, seg);
            end else begin
                hold(0 + (an == 4'b1101) + 2 * (an == 4'b1011) + 3 * (an == 4'b0111),
                     seg, $urandom_range(1, 6));
            end
            if (t == 700) doReset();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 4: consecutive identical samples needed to accept a digit (range 2..255).
REQ-002 SHALL have port iClk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port iRst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port iSeg, input, 7: sampled segment lines, active-low, bit 0 = segment a … bit 6 = segment g.
REQ-005 SHALL have port iAn, input, 4: sampled digit enables, active-low, bit n selects digit n.
REQ-006 SHALL have port oBcd, output, 16: decoded frame, digit n in bits [4n+3:4n].
REQ-007 SHALL have port oValid, output, 4: bit n set when digit n of oBcd decoded to 0..9 or blank.
REQ-008 SHALL have port oFrame, output, 1: one-cycle pulse when oBcd/oValid update.
REQ-009 SHALL have port oErr, output, 1: sticky; set on any illegal pattern or multi-anode sample; cleared only by reset.

Function
REQ-010 Decode table (iSeg -> code) SHALL be: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 1111111->F (blank); any other pattern -> E (illegal).
REQ-011 Sample SHALL be "single" when exactly one iAn bit is 0, "none" when all are 1, "multi" otherwise.
REQ-012 FSM SHALL have states IDLE, TRACK, HOLD.
REQ-013 IDLE: on single sample, load anode/pattern into tracking registers, count=1, go TRACK; on none or multi, stay.
REQ-014 TRACK: if sample equals tracked anode and pattern, count++; when count reaches SETTLE, capture decoded code into staging slot for that digit, set its seen bit, go HOLD.
REQ-015 TRACK: if anode or pattern changes before SETTLE, restart with the new sample (count=1), or go IDLE on none/multi; no capture.
REQ-016 HOLD: stay while sample is unchanged; on any change behave as IDLE for that sample in the same cycle.
REQ-017 Capture of code E SHALL store E, clear that digit's valid staging bit, and set oErr; F and 0..9 set valid staging bit.
REQ-018 Multi sample in any state SHALL set oErr and force IDLE.
REQ-019 When all four seen bits are set after a capture, the next cycle SHALL drive oFrame=1, copy staging to oBcd/oValid, and clear all seen bits; latency from SETTLE-th matching sample to oFrame is 1 cycle.
REQ-020 Recapturing a digit already seen in the current frame SHALL overwrite its staging slot without affecting seen bits.
REQ-021 oBcd/oValid SHALL hold their values between frames.
REQ-022 Counter SHALL saturate at SETTLE; no wrap-around in HOLD.

Reset
REQ-023 Reset SHALL force: state IDLE, count 0, seen bits 0, staging all F, oBcd=16'hFFFF, oValid=4'b0000, oFrame=0, oErr=0.
REQ-024 Reset asserted mid-capture or mid-frame SHALL discard partial frame; no oFrame for it after release.
REQ-025 First sample evaluated SHALL be on the first rising edge after iRst deasserts.

Structure
REQ-026 Shared package SHALL hold the ten digit segment patterns, blank pattern, codes BLANK=F and ILLEGAL=E, FSM state encoding, and SETTLE default.
REQ-027 Combinational pattern-to-code lookup SHALL be a sub-module seg7_pattern_decode (7-bit in, 4-bit code out); everything else stays in this module.

Verification
REQ-028 Reset then drive iAn=1110, iSeg=1111001 for 4 cycles, then digits 1..3 with patterns for 2,3,4 each 4 cycles -> oFrame pulse once, oBcd=16'h4321, oValid=1111, oErr=0.
REQ-029 Digit 0 held only 3 cycles (SETTLE=4) then switch -> no capture of digit 0, no oFrame until digit 0 later held 4 cycles.
REQ-030 Digit 2 pattern 1010101 for 4 cycles in an otherwise legal frame -> oBcd nibble 2 = E, oValid[2]=0, oErr=1 and remains 1 afterwards.
REQ-031 iAn=1100 for one cycle during TRACK -> oErr=1, state IDLE, partial count discarded.
REQ-032 All digits blank (1111111) -> oBcd=16'hFFFF, oValid=1111, oFrame pulse.
REQ-033 iRst asserted after three digits captured, released, one more digit captured -> no oFrame; oBcd=16'hFFFF, oValid=0000.
